gray_counter: RTL
=================

// Module: gray_counter
//
// PURPOSE
// - N-bit up/down counter that produces a registered Gray-code value each step.
// - Upstream source for the gray_to_binary converter: gray_out drives its gray_in.
// - Also provides the binary count (bin_out) so the bench can check the converter
//   against it every cycle.
// - Typical uses: a Gray pointer for FIFO/CDC, or a glitch-free position code.
//
// PARAMETERS
// - N     4  counter / code width in bits (N >= 2)
// - WRAP  1  1: wrap modulo 2^N at the ends; 0: saturate at the ends
//
// PORTS
// - clk       in   1  rising-edge clock
// - rst       in   1  synchronous reset, active-high
// - en        in   1  advance the count by one step this cycle
// - up_dn     in   1  direction: 1 = increment, 0 = decrement
// - load      in   1  load load_bin into the counter
// - load_bin  in   N  binary value to load
// - gray_out  out  N  registered Gray code, equal to bin_out ^ (bin_out >> 1)
// - bin_out   out  N  registered binary count
// - upd       out  1  one-cycle strobe: gray_out changed on this edge
// - tc        out  1  one-cycle strobe: the step crossed or hit an end (see below)
//
// BEHAVIOUR
// - All outputs are registered. Every output changes only on the rising edge of clk.
// - Reset: on a clk edge with rst=1, bin_out=0, gray_out=0, upd=0, tc=0.
// - Priority on each edge: rst > load > en. No action if none is asserted.
// - Latency: a request sampled on edge k is visible on the outputs after edge k.
// - The next binary value nb is computed first. Both registers then load from nb:
//   bin_out <= nb and gray_out <= nb ^ (nb >> 1). They are never inconsistent.
// - Load:
//   - nb = load_bin; upd=1 (even if the value is unchanged); tc=0.
//   - en and up_dn are ignored in that cycle.
// - Step with en=1, up_dn=1:
//   - WRAP=1: nb = bin_out + 1 mod 2^N. The step 2^N-1 -> 0 sets tc=1.
//   - WRAP=0, bin_out = 2^N-1: the count holds, upd=0, tc=1 (held at the end).
// - Step with en=1, up_dn=0:
//   - WRAP=1: nb = bin_out - 1 mod 2^N. The step 0 -> 2^N-1 sets tc=1.
//   - WRAP=0, bin_out = 0: the count holds, upd=0, tc=1.
// - Any other step: upd=1, tc=0.
// - Idle cycle (no rst, load or en): outputs hold; upd=0, tc=0.
// - Invariant: after each en-driven change, gray_out differs from its previous
//   value in exactly one bit, including the wrap steps.
// - Reset mid-operation: rst overrides a load or en in the same cycle.
//   Counting resumes from 0 on the next request.
// - up_dn may change on any cycle; only its value on the edge with en=1 matters.
// - No combinational path from any input to any output.
//
// TESTING (N=4 unless stated)
// 1. Reset, then en=1 up_dn=1 for 16 cycles:
//    -> gray_out = 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000
//    -> tc=1 only on the 1000->0000 step; upd=1 on every step.
// 2. From reset, en=1 up_dn=0:
//    -> bin_out=1111, gray_out=1000, tc=1.
//    -> Next step: bin_out=1110, gray_out=1001, tc=0.
// 3. load=1, load_bin=0101, en=1 in the same cycle:
//    -> bin_out=0101, gray_out=0111, upd=1, tc=0 (load wins over en).
// 4. Count up to bin_out=0110, then rst=1 together with en=1:
//    -> all outputs 0.
//    -> Next en step up gives gray_out=0001.
// 5. WRAP=0: load 1111, then en=1 up_dn=1 for 3 cycles:
//    -> bin_out stays 1111, upd=0, tc=1 each cycle.
//    -> Then up_dn=0: bin_out=1110, tc=0.
// 6. Chain gray_out into gray_to_binary. Apply 200 random cycles of en, up_dn
//    and load with N=4 and N=8:
//    -> converter output == bin_out on every cycle.
//    -> Single-bit Gray change checked on every en-driven update.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code view, plus a Gray-to-binary decoder.
// One-edge latency from request to outputs; no backpressure, every request is taken on its edge.
module gray_counter #(
   parameter int N    = 4,
   parameter bit WRAP = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up_dn,
   input  logic         load,
   input  logic [N-1:0] load_bin,
   output logic [N-1:0] gray_out,
   output logic [N-1:0] bin_out,
   output logic         upd,
   output logic         tc
);

   localparam logic [N-1:0] MAX_V = '1;
   localparam logic [N-1:0] MIN_V = '0;

   logic [N-1:0] bin_q, bin_d;
   logic [N-1:0] gray_q;
   logic         upd_q, upd_d;
   logic         tc_q, tc_d;

   // Next binary value is resolved first; both registers are loaded from it
   // so the Gray and binary views can never disagree.
   always_comb begin
      bin_d = bin_q;
      upd_d = 1'b0;
      tc_d  = 1'b0;
      if (load) begin
         bin_d = load_bin;
         upd_d = 1'b1;
      end else if (en) begin
         if (up_dn) begin
            if (bin_q == MAX_V) begin
               tc_d = 1'b1;
               if (WRAP) begin
                  bin_d = MIN_V;
                  upd_d = 1'b1;
               end
            end else begin
               bin_d = bin_q + 1'b1;
               upd_d = 1'b1;
            end
         end else begin
            if (bin_q == MIN_V) begin
               tc_d = 1'b1;
               if (WRAP) begin
                  bin_d = MAX_V;
                  upd_d = 1'b1;
               end
            end else begin
               bin_d = bin_q - 1'b1;
               upd_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         upd_q  <= 1'b0;
         tc_q   <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= bin_d ^ (bin_d >> 1);
         upd_q  <= upd_d;
         tc_q   <= tc_d;
      end
   end

   assign bin_out  = bin_q;
   assign gray_out = gray_q;
   assign upd      = upd_q;
   assign tc       = tc_q;

endmodule

// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
// Zero latency; no flow control.
module gray_to_binary #(
   parameter int N = 4
) (
   input  logic [N-1:0] gray_in,
   output logic [N-1:0] bin_out
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign bin_out[i] = ^gray_in[N-1:i];
   end

endmodule
